// File: rtl/sram_test_pkg.sv
// Shared types for the SRAM march test engine: FSM states, SRAM pin bundle with its idle
// values, and the Galois LFSR helpers used when SRAM_TEST_LFSR_EN is defined.
package sram_test_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StRdSetup,
        StRdWait,
        StRdSample,
        StDone
    } state_e;

    localparam logic [7:0] LfsrPoly = 8'hB8;

    typedef struct packed {
        logic ce_n;
        logic ce2;
        logic we_n;
        logic oe_n;
        logic dq_oe;
    } pin_ctrl_t;

    localparam pin_ctrl_t IdlePins = '{ce_n: 1'b1, ce2: 1'b0, we_n: 1'b1, oe_n: 1'b1,
                                       dq_oe: 1'b0};

    // Pin levels while sitting in a given state; WEn and OEn are never low together.
    function automatic pin_ctrl_t pins_for_state(input state_e st);
        pin_ctrl_t p;
        p = IdlePins;
        unique case (st)
            StWrSetup, StWrHold: begin
                p.ce_n  = 1'b0;
                p.ce2   = 1'b1;
                p.dq_oe = 1'b1;
            end
            StWrPulse: begin
                p.ce_n  = 1'b0;
                p.ce2   = 1'b1;
                p.dq_oe = 1'b1;
                p.we_n  = 1'b0;
            end
            StRdSetup, StRdWait: begin
                p.ce_n = 1'b0;
                p.ce2  = 1'b1;
                p.oe_n = 1'b0;
            end
            StRdSample: begin
                p.ce_n = 1'b0;
                p.ce2  = 1'b1;
            end
            default: p = IdlePins;
        endcase
        return p;
    endfunction

    function automatic logic [7:0] lfsr_init(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {1'b0, s[7:1]} ^ (s[0] ? LfsrPoly : 8'h00);
    endfunction

endpackage

// File: rtl/sram_test_pattern_gen.sv
// Test pattern source shared by the write and read phases. SRAM_TEST_LFSR_EN selects an 8-bit
// Galois LFSR; otherwise the pattern is the running byte index XOR the seed.
module sram_test_pattern_gen
    import sram_test_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       restart,
    input  logic       advance,
    input  logic [7:0] seed,
    output logic [7:0] data
);

    logic [7:0] seed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q <= 8'h00;
        end else if (load) begin
            seed_q <= seed;
        end
    end

`ifdef SRAM_TEST_LFSR_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 8'h00;
        end else if (load) begin
            lfsr_q <= lfsr_init(seed);
        end else if (restart) begin
            lfsr_q <= lfsr_init(seed_q);
        end else if (advance) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign data = lfsr_q;
`else
    // Tracks the low byte of the SRAM address so the pattern equals A[7:0] ^ seed.
    logic [7:0] idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= 8'h00;
        end else if (load || restart) begin
            idx_q <= 8'h00;
        end else if (advance) begin
            idx_q <= idx_q + 8'h01;
        end
    end

    assign data = idx_q ^ seed_q;
`endif

endmodule

// File: rtl/sram_test_engine.sv
// March test engine for the external async SRAM: write pattern to 0..mem_bytes-1, read back,
// compare. Pattern source chosen by SRAM_TEST_LFSR_EN (see sram_test_pattern_gen).
module sram_test_engine
    import sram_test_pkg::*;
#(
    parameter int unsigned pADDR_WIDTH  = 20,
    parameter int unsigned pWAIT_CYCLES = 2,
    parameter int unsigned pERR_WIDTH   = 16
) (
    input  logic                   usb_clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [pADDR_WIDTH:0]   mem_bytes,
    input  logic [7:0]             seed,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [pERR_WIDTH-1:0]  err_count,
    output logic [pADDR_WIDTH-1:0] first_err_addr,
    output logic [pADDR_WIDTH-1:0] SRAM_A,
    output logic [7:0]             SRAM_DQ_o,
    output logic                   SRAM_DQ_oe,
    input  logic [7:0]             SRAM_DQ_i,
    output logic                   SRAM_CEn,
    output logic                   SRAM_CE2,
    output logic                   SRAM_WEn,
    output logic                   SRAM_OEn
);

    localparam int unsigned WaitW = (pWAIT_CYCLES > 1) ? $clog2(pWAIT_CYCLES) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(pWAIT_CYCLES - 1);
    localparam logic [pADDR_WIDTH:0] MaxBytes = {1'b1, {pADDR_WIDTH{1'b0}}};

    state_e                 state_q, state_d;
    logic [pADDR_WIDTH:0]   addr_q, addr_d, addr_inc;
    logic [pADDR_WIDTH:0]   len_q, len_d;
    logic [WaitW-1:0]       wait_q, wait_d;
    logic                   aborted_q, aborted_d;
    logic [7:0]             rd_q, rd_d;
    logic [pERR_WIDTH-1:0]  err_q, err_d;
    logic [pADDR_WIDTH-1:0] first_q, first_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   addr_last;
    pin_ctrl_t              ctrl_q;

    logic       gen_load, gen_restart, gen_advance;
    logic [7:0] pat_data;

    sram_test_pattern_gen u_pattern (
        .clk     (usb_clk),
        .rst     (reset),
        .load    (gen_load),
        .restart (gen_restart),
        .advance (gen_advance),
        .seed    (seed),
        .data    (pat_data)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wait_d      = wait_q;
        aborted_d   = aborted_q;
        rd_d        = rd_q;
        err_d       = err_q;
        first_d     = first_q;
        done_d      = done_q;
        pass_d      = pass_q;
        gen_load    = 1'b0;
        gen_restart = 1'b0;
        gen_advance = 1'b0;
        addr_inc    = addr_q + 1'b1;
        addr_last   = (addr_inc == len_q);

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    len_d     = mem_bytes[pADDR_WIDTH] ? MaxBytes : mem_bytes;
                    addr_d    = '0;
                    wait_d    = '0;
                    aborted_d = 1'b0;
                    err_d     = '0;
                    first_d   = '0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    gen_load  = 1'b1;
                    state_d   = (mem_bytes == '0) ? StDone : StWrSetup;
                end
            end
            StWrSetup: begin
                wait_d  = '0;
                state_d = StWrPulse;
            end
            StWrPulse: begin
                if (wait_q == WaitLast) begin
                    state_d = StWrHold;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StWrHold: begin
                if (addr_last) begin
                    addr_d      = '0;
                    gen_restart = 1'b1;
                    state_d     = StRdSetup;
                end else begin
                    addr_d      = addr_inc;
                    gen_advance = 1'b1;
                    state_d     = StWrSetup;
                end
            end
            StRdSetup: begin
                wait_d  = '0;
                state_d = StRdWait;
            end
            StRdWait: begin
                // Capture while OEn is still low so RD_SAMPLE can release the bus.
                if (wait_q == WaitLast) begin
                    rd_d    = SRAM_DQ_i;
                    state_d = StRdSample;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StRdSample: begin
                if (rd_q != pat_data) begin
                    if (err_q == '0) begin
                        first_d = addr_q[pADDR_WIDTH-1:0];
                    end
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                end
                if (addr_last) begin
                    state_d = StDone;
                end else begin
                    addr_d      = addr_inc;
                    gen_advance = 1'b1;
                    state_d     = StRdSetup;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                pass_d  = !aborted_q && (err_q == '0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Registered pins follow state_d, so entering StDone releases WEn/OEn immediately.
        if (abort && (state_q != StIdle) && (state_q != StDone)) begin
            aborted_d = 1'b1;
            state_d   = StDone;
        end
    end

    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            len_q     <= '0;
            wait_q    <= '0;
            aborted_q <= 1'b0;
            rd_q      <= '0;
            err_q     <= '0;
            first_q   <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            ctrl_q    <= IdlePins;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            wait_q    <= wait_d;
            aborted_q <= aborted_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            first_q   <= first_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            ctrl_q    <= pins_for_state(state_d);
        end
    end

    assign busy           = (state_q != StIdle);
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign SRAM_A         = addr_q[pADDR_WIDTH-1:0];
    assign SRAM_DQ_o      = pat_data;
    assign SRAM_DQ_oe     = ctrl_q.dq_oe;
    assign SRAM_CEn       = ctrl_q.ce_n;
    assign SRAM_CE2       = ctrl_q.ce2;
    assign SRAM_WEn       = ctrl_q.we_n;
    assign SRAM_OEn       = ctrl_q.oe_n;

endmodule

// File: tb/tb_sram_test_engine.sv
// Directed bench for sram_test_engine with an SRAM model and write/read scoreboards.
module tb_sram_test_engine;

    localparam int unsigned AW = 20;
    localparam int unsigned W  = 2;
    localparam int unsigned EW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   mem_bytes = '0;
    logic [7:0]    seed = '0;
    logic          busy, done, pass;
    logic [EW-1:0] err_count;
    logic [AW-1:0] first_err_addr;
    logic [AW-1:0] SRAM_A;
    logic [7:0]    SRAM_DQ_o, SRAM_DQ_i;
    logic          SRAM_DQ_oe, SRAM_CEn, SRAM_CE2, SRAM_WEn, SRAM_OEn;

    logic [7:0] stuck_mask = 8'hFF;
    logic [7:0] mem [256];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    sram_test_engine #(
        .pADDR_WIDTH  (AW),
        .pWAIT_CYCLES (W),
        .pERR_WIDTH   (EW)
    ) dut (
        .usb_clk        (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .mem_bytes      (mem_bytes),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .SRAM_A         (SRAM_A),
        .SRAM_DQ_o      (SRAM_DQ_o),
        .SRAM_DQ_oe     (SRAM_DQ_oe),
        .SRAM_DQ_i      (SRAM_DQ_i),
        .SRAM_CEn       (SRAM_CEn),
        .SRAM_CE2       (SRAM_CE2),
        .SRAM_WEn       (SRAM_WEn),
        .SRAM_OEn       (SRAM_OEn)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model; stuck_mask models data lines stuck at 0 on the read path.
    always @(posedge clk) begin
        if (!SRAM_CEn && !SRAM_WEn && SRAM_DQ_oe) mem[SRAM_A[7:0]] <= SRAM_DQ_o;
    end
    assign SRAM_DQ_i = (!SRAM_CEn && !SRAM_OEn) ? (mem[SRAM_A[7:0]] & stuck_mask) : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [7:0] s, input int idx);
`ifdef SRAM_TEST_LFSR_EN
        logic [7:0] l;
        l = (s == 8'h00) ? 8'h01 : s;
        for (int k = 0; k < idx; k++) l = {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
        return l;
`else
        return 8'(idx) ^ s;
`endif
    endfunction

    function automatic int lat(input int n);
        return 2 * n * (W + 2) + 2;
    endfunction

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } txn_t;

    txn_t wq[$];
    txn_t rq[$];
    logic we_prev = 1'b1;
    logic oe_prev = 1'b1;
    int we_width = 0;
    int we_pulses = 0;
    int oe_pulses = 0;

    // Per-cycle pin invariants plus write/read scoreboards keyed on strobe falling edges.
    always @(negedge clk) begin
        txn_t t;
        if (!reset) begin
            check("inv_we_oe", SRAM_WEn | SRAM_OEn, 1);
            check("inv_oe_dq", !(SRAM_DQ_oe && !SRAM_OEn), 1);
            if (!SRAM_WEn && we_prev) begin
                we_pulses <= we_pulses + 1;
                we_width  <= 1;
                check("wr_expected", wq.size() != 0, 1);
                if (wq.size() != 0) begin
                    t = wq.pop_front();
                    check("wr_addr", SRAM_A, t.a);
                    check("wr_data", SRAM_DQ_o, t.d);
                    check("wr_dq_oe", SRAM_DQ_oe, 1);
                end
            end else if (!SRAM_WEn) begin
                we_width <= we_width + 1;
            end
            if (SRAM_WEn && !we_prev && !abort) check("we_width", we_width, W);
            if (!SRAM_OEn && oe_prev) begin
                oe_pulses <= oe_pulses + 1;
                check("rd_expected", rq.size() != 0, 1);
                if (rq.size() != 0) begin
                    t = rq.pop_front();
                    check("rd_addr", SRAM_A, t.a);
                end
            end
        end
        we_prev <= SRAM_WEn;
        oe_prev <= SRAM_OEn;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_first"}, first_err_addr, 0);
        check({tag, "_a"}, SRAM_A, 0);
        check({tag, "_dq_o"}, SRAM_DQ_o, 0);
        check({tag, "_dq_oe"}, SRAM_DQ_oe, 0);
        check({tag, "_cen"}, SRAM_CEn, 1);
        check({tag, "_ce2"}, SRAM_CE2, 0);
        check({tag, "_wen"}, SRAM_WEn, 1);
        check({tag, "_oen"}, SRAM_OEn, 1);
    endtask

    // Queue the expected transactions, pulse start for one cycle, return the cycle stamp.
    task automatic start_test(input string tag, input int n, input logic [7:0] s,
                              output int t0);
        for (int i = 0; i < n; i++) begin
            wq.push_back('{a: AW'(i), d: pat(s, i)});
            rq.push_back('{a: AW'(i), d: pat(s, i)});
        end
        @(negedge clk);
        mem_bytes = (AW + 1)'(n);
        seed      = s;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
        check({tag, "_done_clr"}, done, 0);
        check({tag, "_busy"}, busy, 1);
    endtask

    task automatic wait_done(input string tag, input int t0, input int l);
        while (!done && (cyc - t0) < l + 100) @(negedge clk);
        check({tag, "_latency"}, cyc - t0, l - 1);
        check({tag, "_busy_low"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t0, wp0, op0, e, f, found, i;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // 1: ideal SRAM, 4 bytes
        wp0 = we_pulses; op0 = oe_pulses;
        start_test("t1", 4, 8'h5A, t0);
        wait_done("t1", t0, lat(4));
        check("t1_pass", pass, 1);
        check("t1_err", err_count, 0);
        check("t1_first", first_err_addr, 0);
        check("t1_we_pulses", we_pulses - wp0, 4);
        check("t1_oe_pulses", oe_pulses - op0, 4);
        check("t1_queues", wq.size() + rq.size(), 0);

        // 2: data bit 3 stuck at 0, 16 bytes
        stuck_mask = 8'hF7;
        e = 0; f = -1;
        for (int k = 0; k < 16; k++) begin
            if ((pat(8'h00, k) & stuck_mask) != pat(8'h00, k)) begin
                e++;
                if (f < 0) f = k;
            end
        end
        if (f < 0) f = 0;
        start_test("t2", 16, 8'h00, t0);
        wait_done("t2", t0, lat(16));
        check("t2_pass", pass, (e == 0) ? 1 : 0);
        check("t2_err", err_count, e);
        check("t2_first", first_err_addr, f);
        stuck_mask = 8'hFF;

        // 3: zero-length test
        wp0 = we_pulses; op0 = oe_pulses;
        start_test("t3", 0, 8'h3C, t0);
        wait_done("t3", t0, lat(0));
        check("t3_done", done, 1);
        check("t3_pass", pass, 1);
        check("t3_no_strobes", (we_pulses - wp0) + (oe_pulses - op0), 0);

        // 4: abort five cycles into an 8-byte test
        start_test("t4", 8, 8'h77, t0);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        found = 0;
        for (int k = 0; k < W + 1; k++) begin
            @(negedge clk);
            if (SRAM_WEn && SRAM_OEn && SRAM_CEn) begin
                found = 1;
                break;
            end
        end
        check("t4_pins_idle", found, 1);
        i = 0;
        while (!done && i < 50) begin
            @(negedge clk);
            i++;
        end
        check("t4_done", done, 1);
        check("t4_pass", pass, 0);
        abort = 1'b0;
        wq.delete();
        rq.delete();

        // 5: reset during RD_WAIT, then a normal run
        start_test("t5", 2, 8'h33, t0);
        i = 0;
        while (SRAM_OEn && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("t5_reached_read", SRAM_OEn, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("t5_rst");
        @(negedge clk);
        reset = 1'b0;
        wq.delete();
        rq.delete();
        start_test("t5b", 3, 8'hC3, t0);
        wait_done("t5b", t0, lat(3));
        check("t5b_pass", pass, 1);
        check("t5b_err", err_count, 0);

        // 6: start while busy is ignored
        wp0 = we_pulses;
        start_test("t6", 4, 8'h11, t0);
        repeat (6) @(negedge clk);
        mem_bytes = (AW + 1)'(1);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t6", t0, lat(4));
        check("t6_pass", pass, 1);
        check("t6_we_pulses", we_pulses - wp0, 4);
        check("t6_queues", wq.size() + rq.size(), 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
